// File: rtl/spi_frame_assembler.sv
// ============================================================================
//  Module      : spi_frame_assembler
//  Description : Groups the SPI secondary receiver's word stream into frames
//                made of a command word, a length word and payload words. It
//                presents each complete frame on a valid/ready handshake and
//                drives a status reply word for the next SPI transfer.
//                Optional feature macro: FRAME_CHECKSUM_EN. When it is
//                defined, each frame carries a trailing XOR checksum word
//                and the design adds the err_csum output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_assembler #(
    parameter int WORD_BITS   = 8,
    parameter int MAX_PAYLOAD = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             neg_enable,
    input  logic                             word_ready,
    input  logic [WORD_BITS-1:0]             data_word_received,
    output logic [WORD_BITS-1:0]             data_word_to_send,
    output logic                             frame_valid,
    input  logic                             frame_ready,
    output logic [WORD_BITS-1:0]             frame_cmd,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0] frame_len,
    output logic [MAX_PAYLOAD*WORD_BITS-1:0] frame_data,
    output logic                             err_len,
    output logic                             err_overrun
`ifdef FRAME_CHECKSUM_EN
    ,
    output logic                             err_csum
`endif
);

    localparam int                      C_LEN_W = $clog2(MAX_PAYLOAD + 1);
    localparam logic [WORD_BITS-1:0]    C_MAX_W = WORD_BITS'(MAX_PAYLOAD);
    localparam logic [C_LEN_W-1:0]      C_ONE   = C_LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
`ifdef FRAME_CHECKSUM_EN
        S_CHECK   = 3'd3,
`endif
        S_HOLD    = 3'd4,
        S_DISCARD = 3'd5
    } state_t;

    // State entered once the last data-carrying word of a frame is in.
`ifdef FRAME_CHECKSUM_EN
    localparam state_t C_END_STATE = S_CHECK;
`else
    localparam state_t C_END_STATE = S_HOLD;
`endif

    state_t                          state_q,       state_d;
    logic [WORD_BITS-1:0]            cmd_q,         cmd_d;
    logic [C_LEN_W-1:0]              len_q,         len_d;
    logic [C_LEN_W-1:0]              idx_q,         idx_d;
    logic [MAX_PAYLOAD*WORD_BITS-1:0] data_q,       data_d;
    logic                            valid_q,       valid_d;
    logic                            err_len_q,     err_len_d;
    logic                            err_ovr_q,     err_ovr_d;
    logic [WORD_BITS-1:0]            reply_q,       reply_d;
`ifdef FRAME_CHECKSUM_EN
    logic [WORD_BITS-1:0]            csum_q,        csum_d;
    logic                            err_csum_q,    err_csum_d;
`endif

    // Strobes are only meaningful while the chip-select is asserted.
    logic w_word;
    assign w_word = word_ready & ~neg_enable;

    // Next-state, frame capture, sticky error and reply word computation.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        len_d     = len_q;
        idx_d     = idx_q;
        data_d    = data_q;
        err_len_d = err_len_q;
        err_ovr_d = err_ovr_q;
`ifdef FRAME_CHECKSUM_EN
        csum_d     = csum_q;
        err_csum_d = err_csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (w_word) begin
                    cmd_d   = data_word_received;
`ifdef FRAME_CHECKSUM_EN
                    csum_d  = data_word_received;
`endif
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                if (neg_enable) begin
                    state_d = S_IDLE;
                end else if (word_ready) begin
                    if (data_word_received > C_MAX_W) begin
                        err_len_d = 1'b1;
                        state_d   = S_DISCARD;
                    end else begin
                        len_d  = C_LEN_W'(data_word_received);
                        idx_d  = '0;
                        data_d = '0;
`ifdef FRAME_CHECKSUM_EN
                        csum_d = csum_q ^ data_word_received;
`endif
                        state_d = (data_word_received == '0) ? C_END_STATE : S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                if (neg_enable) begin
                    state_d = S_IDLE;
                end else if (word_ready) begin
                    data_d[int'(idx_q)*WORD_BITS +: WORD_BITS] = data_word_received;
                    idx_d = idx_q + C_ONE;
`ifdef FRAME_CHECKSUM_EN
                    csum_d = csum_q ^ data_word_received;
`endif
                    if (idx_q == len_q - C_ONE) begin
                        state_d = C_END_STATE;
                    end
                end
            end

`ifdef FRAME_CHECKSUM_EN
            S_CHECK: begin
                if (neg_enable) begin
                    state_d = S_IDLE;
                end else if (word_ready) begin
                    if (data_word_received == csum_q) begin
                        state_d = S_HOLD;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = S_IDLE;
                    end
                end
            end
`endif

            S_HOLD: begin
                if (frame_ready) begin
                    state_d = S_IDLE;
                    // A word in the accept cycle starts the next frame at once.
                    if (w_word) begin
                        cmd_d   = data_word_received;
`ifdef FRAME_CHECKSUM_EN
                        csum_d  = data_word_received;
`endif
                        state_d = S_LEN;
                    end
                end else if (w_word) begin
                    err_ovr_d = 1'b1;
                end
            end

            S_DISCARD: begin
                if (neg_enable) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_HOLD);

        reply_d    = '0;
        reply_d[3] = valid_d;
        reply_d[2] = err_ovr_d;
        reply_d[1] = err_len_d;
        reply_d[0] = (state_d != S_IDLE);
`ifdef FRAME_CHECKSUM_EN
        reply_d[4] = err_csum_d;
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            err_len_q  <= 1'b0;
            err_ovr_q  <= 1'b0;
            reply_q    <= '0;
`ifdef FRAME_CHECKSUM_EN
            csum_q     <= '0;
            err_csum_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            err_len_q  <= err_len_d;
            err_ovr_q  <= err_ovr_d;
            reply_q    <= reply_d;
`ifdef FRAME_CHECKSUM_EN
            csum_q     <= csum_d;
            err_csum_q <= err_csum_d;
`endif
        end
    end

    assign data_word_to_send = reply_q;
    assign frame_valid       = valid_q;
    assign frame_cmd         = cmd_q;
    assign frame_len         = len_q;
    assign frame_data        = data_q;
    assign err_len           = err_len_q;
    assign err_overrun       = err_ovr_q;
`ifdef FRAME_CHECKSUM_EN
    assign err_csum          = err_csum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_assembler.sv
// ============================================================================
//  Module      : tb_spi_frame_assembler
//  Description : Randomised scoreboard bench for spi_frame_assembler. Frames
//                are modelled as word lists; expected frames are queued when
//                the last word is sent and popped by a handshake monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_frame_assembler;

    localparam int W    = 8;
    localparam int MAXP = 4;
    localparam int LW   = $clog2(MAXP + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              neg_enable = 1'b0;
    logic              word_ready = 1'b0;
    logic [W-1:0]      data_word_received = '0;
    logic [W-1:0]      data_word_to_send;
    logic              frame_valid;
    logic              frame_ready = 1'b0;
    logic [W-1:0]      frame_cmd;
    logic [LW-1:0]     frame_len;
    logic [MAXP*W-1:0] frame_data;
    logic              err_len;
    logic              err_overrun;
`ifdef FRAME_CHECKSUM_EN
    logic              err_csum;
`endif

    spi_frame_assembler #(.WORD_BITS(W), .MAX_PAYLOAD(MAXP)) dut (
        .clk                (clk),
        .rst                (rst),
        .neg_enable         (neg_enable),
        .word_ready         (word_ready),
        .data_word_received (data_word_received),
        .data_word_to_send  (data_word_to_send),
        .frame_valid        (frame_valid),
        .frame_ready        (frame_ready),
        .frame_cmd          (frame_cmd),
        .frame_len          (frame_len),
        .frame_data         (frame_data),
        .err_len            (err_len),
        .err_overrun        (err_overrun)
`ifdef FRAME_CHECKSUM_EN
        ,
        .err_csum           (err_csum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]      cmd;
        logic [LW-1:0]     len;
        logic [MAXP*W-1:0] data;
    } frame_t;

    frame_t exp_q[$];
    int     tests = 0;
    int     fails = 0;

    // Reference model status
    bit held  = 0;   // a complete frame is waiting for acceptance
    bit b2b   = 0;   // next command word goes out together with frame_ready
    bit m_len = 0;
    bit m_ovr = 0;
    bit m_cs  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic strobe(input logic [W-1:0] w);
        data_word_received = w;
        word_ready         = 1'b1;
        if (b2b) frame_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        if (b2b) begin
            frame_ready = 1'b0;
            b2b         = 0;
            held        = 0;
        end
    endtask

    task automatic deselect();
        neg_enable = 1'b1;
        tick();
        neg_enable = 1'b0;
    endtask

    // Status seen at a quiet point, where the block is either idle or holding.
    task automatic quiet_check();
        logic [W-1:0] r;
        r    = '0;
        r[3] = held;
        r[2] = m_ovr;
        r[1] = m_len;
        r[0] = held;
`ifdef FRAME_CHECKSUM_EN
        r[4] = m_cs;
        check("err_csum", err_csum, m_cs);
`endif
        check("reply_word", data_word_to_send, r);
        check("err_len", err_len, m_len);
        check("err_overrun", err_overrun, m_ovr);
        check("frame_valid", frame_valid, held);
    endtask

    task automatic accept();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        held        = 0;
    endtask

    // A strobe while deselected, allowed only when nothing is held.
    task automatic maybe_ghost();
        if (!held && $urandom_range(0, 3) == 0) begin
            neg_enable         = 1'b1;
            word_ready         = 1'b1;
            data_word_received = W'($urandom);
            tick();
            word_ready = 1'b0;
            neg_enable = 1'b0;
        end
    endtask

    // resolve: 0 = accept after a wait, 1 = overrun word then accept, 2 = back-to-back
    task automatic good_frame(input logic [W-1:0] cmd, input int len,
                              input logic [MAXP*W-1:0] pl, input int resolve, input bit bad_cs);
        frame_t       f;
        logic [W-1:0] cs;
        f.cmd  = cmd;
        f.len  = LW'(len);
        f.data = '0;
        cs     = cmd ^ W'(len);
        for (int i = 0; i < len; i++) begin
            f.data[i*W +: W] = pl[i*W +: W];
            cs = cs ^ pl[i*W +: W];
        end
        strobe(cmd);
        gap();
        strobe(W'(len));
        for (int i = 0; i < len; i++) begin
            gap();
            strobe(pl[i*W +: W]);
        end
`ifdef FRAME_CHECKSUM_EN
        gap();
        if (bad_cs) begin
            strobe(cs ^ W'(1));
            m_cs = 1;
            quiet_check();
            return;
        end
        strobe(cs);
`else
        if (bad_cs) cs = '0;
`endif
        check("frame_valid_latency", frame_valid, 1'b1);
        exp_q.push_back(f);
        held = 1;
        if (resolve == 1) begin
            repeat ($urandom_range(0, 2)) tick();
            strobe(W'($urandom));
            m_ovr = 1;
            quiet_check();
        end
        if (resolve == 2) begin
            b2b = 1;
        end else begin
            repeat ($urandom_range(0, 3)) tick();
            accept();
            quiet_check();
        end
    endtask

    task automatic too_long(input logic [W-1:0] cmd, input logic [W-1:0] len);
        strobe(cmd);
        gap();
        strobe(len);
        m_len = 1;
        repeat ($urandom_range(0, 2)) begin
            gap();
            strobe(W'($urandom));
        end
        gap();
        deselect();
        quiet_check();
    endtask

    // n = words sent after the command before chip-select is released
    task automatic abort_frame(input logic [W-1:0] cmd, input int len,
                               input logic [MAXP*W-1:0] pl, input int n);
        strobe(cmd);
        if (n > 0) begin
            gap();
            strobe(W'(len));
        end
        for (int i = 0; i < n - 1; i++) begin
            gap();
            strobe(pl[i*W +: W]);
        end
        gap();
        deselect();
        quiet_check();
    endtask

    // Scoreboard monitor: pop and compare on every handshake.
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got cmd %0h len %0d, expected no frame", frame_cmd, frame_len);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                check("frame_cmd", frame_cmd, f.cmd);
                check("frame_len", frame_len, f.len);
                check("frame_data", frame_data, f.data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MAXP*W-1:0] pl;
        int                len;
        int                kind;
        repeat (3) tick();
        check("reset_reply", data_word_to_send, '0);
        check("reset_valid", frame_valid, 1'b0);
        check("reset_cmd", frame_cmd, '0);
        check("reset_len", frame_len, '0);
        check("reset_data", frame_data, '0);
        check("reset_err_len", err_len, 1'b0);
        check("reset_err_overrun", err_overrun, 1'b0);
        rst = 1'b0;
        tick();

        // Basic two-word frame
        good_frame(8'h11, 2, 32'h0000BBAA, 0, 0);
        // Zero-length frame
        good_frame(8'h22, 0, '0, 0, 0);
        // Oversized length then a normal frame
        too_long(8'h33, 8'h05);
        good_frame(8'h5A, 4, 32'hDEADBEEF, 0, 0);
        // Deselect mid-frame, then a clean frame
        abort_frame(8'h44, 3, 32'h00000001, 2);
        good_frame(8'h55, 1, 32'h0000007E, 0, 0);
        // Overrun while holding, then back-to-back acceptance
        good_frame(8'h60, 1, 32'h00000099, 1, 0);
        good_frame(8'h61, 2, 32'h00001234, 2, 0);
        good_frame(8'h66, 1, 32'h00000042, 0, 0);
`ifdef FRAME_CHECKSUM_EN
        good_frame(8'h10, 1, 32'h00000020, 0, 0);
        good_frame(8'h10, 1, 32'h00000020, 0, 1);
`endif

        for (int it = 0; it < 200; it++) begin
            maybe_ghost();
            pl   = {$urandom, $urandom};
            kind = $urandom_range(0, 9);
            if (kind < 6) begin
                len = $urandom_range(0, MAXP);
                good_frame(W'($urandom), len, pl, $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
            end else if (kind < 8) begin
                len = $urandom_range(1, MAXP);
`ifdef FRAME_CHECKSUM_EN
                abort_frame(W'($urandom), len, pl, $urandom_range(0, len + 1));
`else
                abort_frame(W'($urandom), len, pl, $urandom_range(0, len));
`endif
            end else begin
                too_long(W'($urandom), W'($urandom_range(MAXP + 1, (1 << W) - 1)));
            end
        end

        if (b2b) begin
            b2b = 0;
            accept();
        end
        repeat (4) tick();
        quiet_check();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
